// File: rtl/tape_pulse_encoder.sv
// Serialises one byte per start strobe, MSB first, as clock/data pulse pairs
// on the emulated cassette input line; done pulses once after the last cell.
module tape_pulse_encoder #(
  parameter int   PULSE_LEN   = 1400,
  parameter int   DATA_OFFSET = 2800,
  parameter int   BIT_CELL    = 5600,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int CW = $clog2(BIT_CELL);

  // One extra bit so DATA_OFFSET+PULSE_LEN == BIT_CELL == 2**CW still fits.
  localparam logic [CW:0]   C_PULSE_END  = (CW+1)'(PULSE_LEN);
  localparam logic [CW:0]   C_DATA_START = (CW+1)'(DATA_OFFSET);
  localparam logic [CW:0]   C_DATA_END   = (CW+1)'(DATA_OFFSET + PULSE_LEN);
  localparam logic [CW-1:0] C_CYC_LAST   = CW'(BIT_CELL - 1);

  if (PULSE_LEN < 1 || DATA_OFFSET < PULSE_LEN ||
      DATA_OFFSET + PULSE_LEN > BIT_CELL) begin : g_param_check
    $error("tape_pulse_encoder: illegal PULSE_LEN/DATA_OFFSET/BIT_CELL");
  end

  typedef enum logic [1:0] {S_IDLE, S_CELL, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shreg;
  logic            r_dout;
  logic            r_busy;
  logic            r_done;
  logic            w_dout_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic            w_cell_end;
  logic [CW:0]     w_cyc_ext;
  logic            w_clk_pulse;
  logic            w_data_pulse;

  assign w_cyc_ext    = {1'b0, r_cyc};
  assign w_cell_end   = (r_cyc == C_CYC_LAST);
  assign w_clk_pulse  = (w_cyc_ext < C_PULSE_END);
  assign w_data_pulse = r_shreg[7] && (w_cyc_ext >= C_DATA_START) &&
                        (w_cyc_ext < C_DATA_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CELL;
      S_CELL:  if (w_cell_end && (r_bit_idx == 3'd0)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they trail the state/counter by one cycle.
  always_comb begin
    w_dout_next = IDLE_LEVEL;
    w_busy_next = 1'b0;
    w_done_next = 1'b0;
    case (r_state)
      S_CELL: begin
        w_busy_next = 1'b1;
        if (w_clk_pulse || w_data_pulse) w_dout_next = ~IDLE_LEVEL;
      end
      S_DONE: begin
        w_busy_next = 1'b1;
        w_done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= IDLE_LEVEL;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_dout <= w_dout_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc     <= '0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg   <= din;
            r_bit_idx <= 3'd7;
            r_cyc     <= '0;
          end
        end
        S_CELL: begin
          if (w_cell_end) begin
            r_cyc   <= '0;
            r_shreg <= {r_shreg[6:0], 1'b0};
            if (r_bit_idx != 3'd0) r_bit_idx <= r_bit_idx - 3'd1;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_tape_pulse_encoder.sv
// Bench for tape_pulse_encoder: table of bytes with expected 64-cycle waveforms,
// scoreboard queue checked by a monitor whenever done is seen.
module tb_tape_pulse_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = 8'd0;
  logic       busy;
  logic       done;
  logic       dout;

  tape_pulse_encoder #(
    .PULSE_LEN  (2),
    .DATA_OFFSET(4),
    .BIT_CELL   (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [7:0]  din;
    logic [63:0] wave;
    int          pulses;
  } vec_t;

  typedef struct {
    logic [7:0]  din;
    logic [63:0] wave;
    int          pulses;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Collects dout while a byte is in flight, checks it when done appears.
  task automatic monitor();
    logic [63:0] cap = '0;
    int          cap_n = 0;
    logic        prev_done = 1'b0;
    logic        prev;
    int          rises;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_width", {63'd0, done}, 64'd0);
      prev_done = done;
      if (!reset_n) begin
        cap   = '0;
        cap_n = 0;
      end else if (busy && !done) begin
        cap = {cap[62:0], dout};
        cap_n++;
      end else if (done) begin
        chk("done_expected", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          rises = 0;
          prev  = 1'b0;
          for (int i = 63; i >= 0; i--) begin
            if (cap[i] && !prev) rises++;
            prev = cap[i];
          end
          chk("wave", cap, e.wave);
          chk("bit_cycles", 64'(cap_n), 64'd64);
          chk("pulse_count", 64'(rises), 64'(e.pulses));
          chk("done_latency", 64'(cycle), 64'(e.start_cyc + 65));
          chk("busy_in_done", {63'd0, busy}, 64'd1);
          chk("dout_in_done", {63'd0, dout}, 64'd0);
          $display("byte %02h: wave %016h pulses %0d start@%0d done@%0d",
                   e.din, cap, rises, e.start_cyc, cycle);
        end
        cap   = '0;
        cap_n = 0;
      end else begin
        chk("idle_dout", {63'd0, dout}, 64'd0);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [63:0] w, input int p);
    exp_t e;
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = '{din: d, wave: w, pulses: p, start_cyc: cycle};
    sb.push_back(e);
    start = 1'b0;
    din   = 8'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{din: 8'hA5, wave: 64'hCCC0CCC0C0CCC0CC, pulses: 12};
    vecs[1] = '{din: 8'h00, wave: 64'hC0C0C0C0C0C0C0C0, pulses: 8};
    vecs[2] = '{din: 8'hFF, wave: 64'hCCCCCCCCCCCCCCCC, pulses: 16};
    vecs[3] = '{din: 8'h80, wave: 64'hCCC0C0C0C0C0C0C0, pulses: 9};
    vecs[4] = '{din: 8'h3C, wave: 64'hC0C0CCCCCCCCC0C0, pulses: 12};

    fork
      monitor();
    join_none

    // Async reset before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_dout", {63'd0, dout}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din, vecs[i].wave, vecs[i].pulses);
      wait_empty();
    end

    // start during CELL with another byte must be ignored.
    send(8'hA5, 64'hCCC0CCC0C0CCC0CC, 12);
    repeat (20) @(posedge clk);
    #1;
    din   = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = 8'h33;
    wait_empty();

    // Reset at cell 3 cycle 5 of 0xFF, where dout is in a data pulse.
    send(8'hFF, 64'hCCCCCCCCCCCCCCCC, 16);
    repeat (30) @(posedge clk);
    #3;
    chk("pre_rst_dout", {63'd0, dout}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_dout", {63'd0, dout}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    sb.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (80) @(posedge clk);
    send(8'hA5, 64'hCCC0CCC0C0CCC0CC, 12);
    wait_empty();

    // start held high: bytes accepted every 66 cycles.
    @(negedge clk);
    din   = 8'h5A;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = '{din: 8'h5A, wave: 64'hC0CCC0CCCCC0CCC0, pulses: 12, start_cyc: cycle};
    sb.push_back(e);
    din = 8'hC3;
    e = '{din: 8'hC3, wave: 64'hCCCCC0C0C0C0CCCC, pulses: 12, start_cyc: cycle + 66};
    sb.push_back(e);
    repeat (66) @(posedge clk);
    #1;
    din = 8'h96;
    e = '{din: 8'h96, wave: 64'hCCC0C0CCC0CCCCC0, pulses: 12, start_cyc: cycle + 66};
    sb.push_back(e);
    repeat (66) @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_pulse_encoder.md
Name: tape_pulse_encoder

Overview:
- Downstream stage of the cassette playback block: takes one byte per `start` strobe and serialises it, MSB first, onto the emulated tape input line.
- Uses the EG2000/TRS-80 style pulse encoding: each bit cell carries a clock pulse, then a data pulse that is present only for a 1.
- Signals completion with a one-cycle `done`, so the playback FSM can advance its SDRAM address and fetch the next byte.
- `dout` drives the machine's cassette input comparator.

Parameters:
- PULSE_LEN, default 1400, width of each clock/data pulse in clk cycles.
- DATA_OFFSET, default 2800, cycle within the bit cell at which the data pulse starts.
- BIT_CELL, default 5600, length of one bit cell in clk cycles.
- IDLE_LEVEL, default 0, level of `dout` outside pulses; pulses drive ~IDLE_LEVEL.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  byte request; sampled only in IDLE
- din  input  8  byte to encode; latched on accepted start
- busy  output  1  high from the cycle after an accepted start until done is dropped
- done  output  1  one-cycle pulse after the last bit cell
- dout  output  1  encoded tape waveform, registered

Behaviour:
- Reset value of every output, reset_n low (async):
  - state=IDLE, busy=0, done=0, dout=IDLE_LEVEL.
  - Internal counters and the shift register are cleared.
- Reset mid-byte aborts immediately; no done is produced.
- Parameter legality, checked by an elaboration-time assertion:
  - PULSE_LEN >= 1
  - DATA_OFFSET >= PULSE_LEN
  - DATA_OFFSET + PULSE_LEN <= BIT_CELL
- Counter widths: cycle counter is $clog2(BIT_CELL) bits; bit index is 3 bits. Counters wrap only under FSM control.
- FSM states: IDLE, CELL, DONE.
- IDLE:
  - dout=IDLE_LEVEL, busy=0.
  - start=1 latches din into shreg, sets bit_idx=7 and cyc=0, goes to CELL.
- CELL (busy=1): registered `dout` for cycle counter value `cyc`:
  - ~IDLE_LEVEL when cyc < PULSE_LEN (clock pulse).
  - ~IDLE_LEVEL when DATA_OFFSET <= cyc < DATA_OFFSET+PULSE_LEN and shreg[7]=1 (data pulse).
  - IDLE_LEVEL otherwise.
- End of a bit cell (cyc == BIT_CELL-1): cyc returns to 0 and shreg shifts left one place.
  - If bit_idx != 0: bit_idx decrements.
  - If bit_idx == 0: go to DONE.
- DONE: done=1, busy=1, dout=IDLE_LEVEL for exactly one cycle, then IDLE.
- Timing:
  - Accepted start at edge T: first clock-pulse cycle is visible on dout after edge T+1.
  - done is high in the cycle after edge T+1+8*BIT_CELL.
  - Next byte can be accepted at the edge after done.
- start while busy (CELL or DONE) is ignored. din may change freely after acceptance.
- start held high continuously: a new byte is accepted on each return to IDLE, giving back-to-back bytes separated by the 1-cycle DONE plus the 1-cycle IDLE.
- A byte of 0x00 still produces 8 clock pulses.

Test Plan (bench uses PULSE_LEN=2, DATA_OFFSET=4, BIT_CELL=8, IDLE_LEVEL=0):
- Reset, then idle 20 cycles -> dout=0, busy=0, done=0 throughout.
- start with din=0xA5 -> per cell, 1-bits give dout 11001100 and 0-bits give 11000000. Sequence is MSB first: 1,0,1,0,0,1,0,1. done is a single pulse 65 cycles after the start edge.
- din=0x00 then din=0xFF -> exactly 8 pulses, then exactly 16 pulses; pulse spacing matches the cell timing.
- start pulsed again mid-byte with a different din -> ignored; output bits still match the originally latched byte; single done.
- reset_n dropped at cell 3 cycle 5 -> dout=0, busy=0 immediately (async); no done; a fresh start afterwards encodes correctly from bit 7.
- start held high with din changing each byte -> consecutive bytes encoded, gap between last cell of one and first pulse of next = 2 cycles, one done per byte.
